// File: rtl/regfile_writeback_unit_pkg.sv
// Shared types and constants for the register-file write-back unit.
// The result entry pairs a destination index with its 64-bit value.
package regfile_writeback_unit_pkg;

  localparam int XLEN     = 64;
  localparam int RIDX     = 6;
  localparam int NREGS    = 32;
  localparam int REG_BITS = $clog2(NREGS);

  typedef struct packed {
    logic [RIDX-1:0] rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  localparam logic [REG_BITS-1:0] ZERO_REG = '0;

  // Only the low REG_BITS of an index name a register; x0 is hardwired zero.
  function automatic logic is_zero_reg(input logic [RIDX-1:0] idx);
    return idx[REG_BITS-1:0] == ZERO_REG;
  endfunction

  function automatic logic same_reg(input logic [RIDX-1:0] a,
                                    input logic [RIDX-1:0] b);
    return a[REG_BITS-1:0] == b[REG_BITS-1:0];
  endfunction

endpackage

// File: rtl/regfile_writeback_unit_wb_result_fifo.sv
// Dual-push, single-pop circular result queue. Slot 0 of the age view is
// the oldest entry, so a forward search scanning upward finds the youngest last.
module wb_result_fifo
  import regfile_writeback_unit_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push0,
  input  wb_entry_t        i_entry0,
  input  logic             i_push1,
  input  wb_entry_t        i_entry1,
  input  logic             i_pop,
  output wb_entry_t        o_head,
  output logic [CW-1:0]    o_count,
  output wb_entry_t        o_age_entry [DEPTH],
  output logic [DEPTH-1:0] o_age_valid
);

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  wb_entry_t     r_mem [DEPTH];
  logic [PW-1:0] w_tail_nxt;

  assign w_tail_nxt = r_tail + PW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_pop) r_head <= r_head + PW'(1);
      r_tail  <= r_tail + PW'(i_push0) + PW'(i_push1);
      r_count <= r_count + CW'(i_push0) + CW'(i_push1) - CW'(i_pop);
    end
  end

  // Port 0 always takes the lower slot, keeping it older than port 1.
  always_ff @(posedge clk) begin
    if (i_push0) r_mem[r_tail] <= i_entry0;
    if (i_push1) begin
      if (i_push0) r_mem[w_tail_nxt] <= i_entry1;
      else         r_mem[r_tail]     <= i_entry1;
    end
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      o_age_entry[k] = r_mem[r_head + PW'(k)];
      o_age_valid[k] = CW'(k) < r_count;
    end
  end

  assign o_head  = r_mem[r_head];
  assign o_count = r_count;

endmodule

// File: rtl/regfile_writeback_unit.sv
// Write-back initiator: merges load and ALU results into an in-order queue,
// retires one register-file write per cycle, and forwards pending values.
module regfile_writeback_unit #(
  parameter int DEPTH = 4,
  parameter int XLEN  = regfile_writeback_unit_pkg::XLEN,
  parameter int RIDX  = regfile_writeback_unit_pkg::RIDX
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld_valid,
  input  logic [RIDX-1:0] ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            ld_ready,
  input  logic            alu_valid,
  input  logic [RIDX-1:0] alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  output logic [RIDX-1:0] rd,
  output logic [XLEN-1:0] wrt_data,
  output logic            RegWrite,
  input  logic [RIDX-1:0] fwd_rs1,
  input  logic [RIDX-1:0] fwd_rs2,
  output logic            fwd_hit1,
  output logic            fwd_hit2,
  output logic [XLEN-1:0] fwd_data1,
  output logic [XLEN-1:0] fwd_data2,
  output logic            busy
);
  import regfile_writeback_unit_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]    w_count;
  logic [CW-1:0]    w_free;
  logic             w_ld_fire;
  logic             w_alu_fire;
  logic             w_ld_push;
  logic             w_alu_push;
  logic             w_pop;
  wb_entry_t        w_ld_entry;
  wb_entry_t        w_alu_entry;
  wb_entry_t        w_head;
  wb_entry_t        w_age_entry [DEPTH];
  logic [DEPTH-1:0] w_age_valid;
  logic             w_unused_rs_hi;

  logic [RIDX-1:0]  r_rd_p1;
  logic [XLEN-1:0]  r_data_p1;
  logic             r_we_p1;

  // Free slots are counted before the same-cycle pop, so a retiring entry
  // never makes room for a push in the cycle it leaves.
  assign w_free    = CW'(DEPTH) - w_count;
  assign ld_ready  = w_free >= CW'(1);
  assign alu_ready = (w_free >= CW'(2)) || ((w_free == CW'(1)) && !ld_valid);

  assign w_ld_fire  = ld_valid && ld_ready;
  assign w_alu_fire = alu_valid && alu_ready;
  assign w_ld_push  = w_ld_fire && !is_zero_reg(ld_rd);
  assign w_alu_push = w_alu_fire && !is_zero_reg(alu_rd);
  assign w_pop      = w_count != '0;

  always_comb begin
    w_ld_entry.rd    = ld_rd;
    w_ld_entry.data  = ld_data;
    w_alu_entry.rd   = alu_rd;
    w_alu_entry.data = alu_data;
  end

  wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push0     (w_ld_push),
    .i_entry0    (w_ld_entry),
    .i_push1     (w_alu_push),
    .i_entry1    (w_alu_entry),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_age_entry (w_age_entry),
    .o_age_valid (w_age_valid)
  );

  // ---- stage p1: registered register-file write port ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_p1   <= '0;
      r_data_p1 <= '0;
      r_we_p1   <= 1'b0;
    end else if (w_pop) begin
      r_rd_p1   <= w_head.rd;
      r_data_p1 <= w_head.data;
      r_we_p1   <= 1'b1;
    end else begin
      r_we_p1   <= 1'b0;
    end
  end

  assign rd       = r_rd_p1;
  assign wrt_data = r_data_p1;
  assign RegWrite = r_we_p1;
  assign busy     = w_pop || r_we_p1;

  // Output stage is the oldest pending value; later queue matches override it.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    fwd_hit2  = 1'b0;
    fwd_data2 = '0;
    if (r_we_p1 && same_reg(r_rd_p1, fwd_rs1)) begin
      fwd_hit1  = 1'b1;
      fwd_data1 = r_data_p1;
    end
    if (r_we_p1 && same_reg(r_rd_p1, fwd_rs2)) begin
      fwd_hit2  = 1'b1;
      fwd_data2 = r_data_p1;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (w_age_valid[k] && same_reg(w_age_entry[k].rd, fwd_rs1)) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = w_age_entry[k].data;
      end
      if (w_age_valid[k] && same_reg(w_age_entry[k].rd, fwd_rs2)) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = w_age_entry[k].data;
      end
    end
    if (is_zero_reg(fwd_rs1)) begin
      fwd_hit1  = 1'b0;
      fwd_data1 = '0;
    end
    if (is_zero_reg(fwd_rs2)) begin
      fwd_hit2  = 1'b0;
      fwd_data2 = '0;
    end
  end

  assign w_unused_rs_hi = ^{fwd_rs1[RIDX-1:REG_BITS], fwd_rs2[RIDX-1:REG_BITS]};

endmodule

// File: tb/tb_regfile_writeback_unit.sv
// Directed bench for regfile_writeback_unit with a small queue model for
// the sustained-traffic section.
module tb_regfile_writeback_unit;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        ld_valid;
  logic [5:0]  ld_rd;
  logic [63:0] ld_data;
  logic        ld_ready;
  logic        alu_valid;
  logic [5:0]  alu_rd;
  logic [63:0] alu_data;
  logic        alu_ready;
  logic [5:0]  rd;
  logic [63:0] wrt_data;
  logic        RegWrite;
  logic [5:0]  fwd_rs1;
  logic [5:0]  fwd_rs2;
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [63:0] fwd_data1;
  logic [63:0] fwd_data2;
  logic        busy;

  int n_chk = 0;
  int n_bad = 0;

  regfile_writeback_unit #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .ld_valid  (ld_valid),
    .ld_rd     (ld_rd),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .rd        (rd),
    .wrt_data  (wrt_data),
    .RegWrite  (RegWrite),
    .fwd_rs1   (fwd_rs1),
    .fwd_rs2   (fwd_rs2),
    .fwd_hit1  (fwd_hit1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data1 (fwd_data1),
    .fwd_data2 (fwd_data2),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [5:0]  rd;
    logic [63:0] data;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cnt, n_acc, n_wr, ld_n, alu_n;
  logic exp_ldr, exp_alur, ldf, alf, pop;

  initial begin
    rst = 1'b1;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    fwd_rs1 = '0; fwd_rs2 = '0;
    tick; tick;
    rst = 1'b0;
    chk("rst_we", RegWrite, 1'b0);
    chk("rst_rd", rd, 6'd0);
    chk("rst_data", wrt_data, 64'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ldr", ld_ready, 1'b1);
    chk("rst_alur", alu_ready, 1'b1);
    chk("rst_hit1", fwd_hit1, 1'b0);

    // ALU-only result
    alu_valid = 1'b1; alu_rd = 6'd5; alu_data = 64'hA; fwd_rs1 = 6'd5;
    tick;
    alu_valid = 1'b0;
    chk("alu_we0", RegWrite, 1'b0);
    chk("alu_busy0", busy, 1'b1);
    chk("alu_hitq", fwd_hit1, 1'b1);
    chk("alu_fwdq", fwd_data1, 64'hA);
    tick;
    chk("alu_we1", RegWrite, 1'b1);
    chk("alu_rd1", rd, 6'd5);
    chk("alu_data1", wrt_data, 64'hA);
    chk("alu_busy1", busy, 1'b1);
    tick;
    chk("alu_we2", RegWrite, 1'b0);
    chk("alu_busy2", busy, 1'b0);
    chk("alu_rdhold", rd, 6'd5);
    chk("alu_datahold", wrt_data, 64'hA);

    // Simultaneous load and ALU to the same register
    ld_valid = 1'b1; ld_rd = 6'd3; ld_data = 64'h11;
    alu_valid = 1'b1; alu_rd = 6'd3; alu_data = 64'h22;
    fwd_rs1 = 6'd3; fwd_rs2 = 6'd4;
    tick;
    ld_valid = 1'b0; alu_valid = 1'b0;
    chk("sim_hit1", fwd_hit1, 1'b1);
    chk("sim_fwd1", fwd_data1, 64'h22);
    chk("sim_hit2", fwd_hit2, 1'b0);
    chk("sim_we0", RegWrite, 1'b0);
    tick;
    chk("sim_we1", RegWrite, 1'b1);
    chk("sim_data1", wrt_data, 64'h11);
    chk("sim_rd1", rd, 6'd3);
    chk("sim_fwd_after1", fwd_data1, 64'h22);
    tick;
    chk("sim_we2", RegWrite, 1'b1);
    chk("sim_data2", wrt_data, 64'h22);
    chk("sim_hit_out", fwd_hit1, 1'b1);
    chk("sim_fwd_out", fwd_data1, 64'h22);
    tick;
    chk("sim_we3", RegWrite, 1'b0);
    chk("sim_hit_none", fwd_hit1, 1'b0);
    chk("sim_busy3", busy, 1'b0);

    // Sustained traffic against a queue model
    fwd_rs1 = '0; fwd_rs2 = '0;
    cnt = 0; n_acc = 0; n_wr = 0; ld_n = 0; alu_n = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      ld_valid  = (cyc < 20) && (cyc % 3 != 2);
      ld_rd     = 6'((ld_n % 31) + 1);
      ld_data   = 64'h1000 + 64'(ld_n);
      alu_valid = (alu_n < 12);
      alu_rd    = 6'(((alu_n * 7) % 31) + 1);
      alu_data  = 64'h2000 + 64'(alu_n);
      #1;
      exp_ldr  = (cnt < DEPTH);
      exp_alur = ((DEPTH - cnt) >= 2) || (((DEPTH - cnt) == 1) && !ld_valid);
      chk("fill_ldr", ld_ready, exp_ldr);
      chk("fill_alur", alu_ready, exp_alur);
      ldf = ld_valid && exp_ldr;
      alf = alu_valid && exp_alur;
      pop = (cnt > 0);
      if (pop) e = q.pop_front();
      tick;
      if (pop) begin
        chk("fill_we", RegWrite, 1'b1);
        chk("fill_data", wrt_data, e.data);
        chk("fill_rd", rd, e.rd);
        n_wr++;
      end else begin
        chk("fill_idle", RegWrite, 1'b0);
      end
      if (ldf) begin
        q.push_back('{ld_rd, ld_data});
        ld_n++; n_acc++;
      end
      if (alf) begin
        q.push_back('{alu_rd, alu_data});
        alu_n++; n_acc++;
      end
      cnt = cnt + int'(ldf) + int'(alf) - int'(pop);
    end
    ld_valid = 1'b0; alu_valid = 1'b0;
    chk("fill_count", 64'(n_wr), 64'(n_acc));
    chk("fill_alu_all", 64'(alu_n), 64'd12);
    chk("fill_empty", 64'(cnt), 64'd0);
    chk("fill_busy", busy, 1'b0);

    // Writes to x0 complete the handshake but never retire
    ld_valid = 1'b1; ld_rd = 6'd0; ld_data = 64'hDEAD;
    alu_valid = 1'b1; alu_rd = 6'd32; alu_data = 64'hBEEF;
    fwd_rs1 = 6'd0; fwd_rs2 = 6'd32;
    #1;
    chk("x0_ldr", ld_ready, 1'b1);
    chk("x0_alur", alu_ready, 1'b1);
    tick;
    ld_valid = 1'b0; alu_valid = 1'b0;
    chk("x0_busy", busy, 1'b0);
    chk("x0_hit1", fwd_hit1, 1'b0);
    chk("x0_hit2", fwd_hit2, 1'b0);
    chk("x0_we0", RegWrite, 1'b0);
    tick;
    chk("x0_we1", RegWrite, 1'b0);

    // Reset with three entries queued
    ld_valid = 1'b1; ld_rd = 6'd7; ld_data = 64'h71;
    alu_valid = 1'b1; alu_rd = 6'd8; alu_data = 64'h81;
    tick;
    ld_rd = 6'd9; ld_data = 64'h91;
    alu_rd = 6'd10; alu_data = 64'hA1;
    tick;
    ld_valid = 1'b0; alu_valid = 1'b0;
    chk("rm_we_pre", RegWrite, 1'b1);
    chk("rm_data_pre", wrt_data, 64'h71);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rm_we0", RegWrite, 1'b0);
    chk("rm_busy0", busy, 1'b0);
    chk("rm_rd0", rd, 6'd0);
    chk("rm_data0", wrt_data, 64'd0);
    tick;
    chk("rm_we1", RegWrite, 1'b0);
    chk("rm_busy1", busy, 1'b0);
    fwd_rs1 = 6'd9;
    #1;
    chk("rm_hit", fwd_hit1, 1'b0);
    alu_valid = 1'b1; alu_rd = 6'd12; alu_data = 64'h5;
    tick;
    alu_valid = 1'b0;
    tick;
    chk("rm_after_we", RegWrite, 1'b1);
    chk("rm_after_rd", rd, 6'd12);
    chk("rm_after_data", wrt_data, 64'h5);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
